spi_slave_param: RTL and testbench

Parametrised SPI slave front-end sitting between an external SPI master and the single-port RAM controller. It deserialises command frames of DATA_W+2 bits (2-bit opcode + DATA_W payload) into a parallel word for the RAM side. It serialises RAM read data back on MISO. Compared with the fixed 10-bit slave, it adds:
- a generic data width;
- read-sequence checking (read-data requires a prior read-address);
- a bounded wait for RAM read data;
- explicit error and abort indications.

---
 rtl/spi_slave_param.sv | 189 ++++++++++++++++++
 tb/tb_spi_slave_param.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_param.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_param
// Brief    : Parametrised SPI slave front-end for the single-port RAM
//            controller. Checks read sequencing, bounds the read-data wait,
//            and reports errors and aborts.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_param #(
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              MISO,
    output logic              rx_valid,
    output logic [DATA_W+1:0] rx_data,
    output logic              err,
    output logic              abort
);

    localparam int c_w   = DATA_W + 2;
    localparam int c_bcw = $clog2(c_w + 1);
    localparam int c_tcw = $clog2(TX_TIMEOUT + 1);

    localparam logic [c_bcw-1:0] c_last_bit = c_bcw'(c_w - 1);
    localparam logic [c_bcw-1:0] c_tx_bits  = c_bcw'(DATA_W);
    localparam logic [c_tcw-1:0] c_tout     = c_tcw'(TX_TIMEOUT);

    localparam logic [1:0] c_op_wr_addr = 2'b00;
    localparam logic [1:0] c_op_wr_data = 2'b01;
    localparam logic [1:0] c_op_rd_addr = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RECV    = 3'd1,
        S_TX_WAIT = 3'd2,
        S_SEND    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            r_state,    w_state;
    logic [c_w-2:0]    r_shift,    w_shift;
    logic [c_bcw-1:0]  r_bit_cnt,  w_bit_cnt;
    logic [c_tcw-1:0]  r_tout_cnt, w_tout_cnt;
    logic [DATA_W-2:0] r_tx_shift, w_tx_shift;
    logic              r_miso,     w_miso;
    logic [c_w-1:0]    r_rx_data,  w_rx_data;
    logic              r_rx_valid, w_rx_valid;
    logic              r_err,      w_err;
    logic              r_abort,    w_abort;
    logic              r_rd_seen,  w_rd_seen;
    logic [c_w-1:0]    w_frame;
    logic [c_tcw-1:0]  w_tout_inc;

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_tout_cnt <= '0;
            r_tx_shift <= '0;
            r_miso     <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_err      <= 1'b0;
            r_abort    <= 1'b0;
            r_rd_seen  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_shift    <= w_shift;
            r_bit_cnt  <= w_bit_cnt;
            r_tout_cnt <= w_tout_cnt;
            r_tx_shift <= w_tx_shift;
            r_miso     <= w_miso;
            r_rx_data  <= w_rx_data;
            r_rx_valid <= w_rx_valid;
            r_err      <= w_err;
            r_abort    <= w_abort;
            r_rd_seen  <= w_rd_seen;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_shift    = r_shift;
        w_bit_cnt  = r_bit_cnt;
        w_tout_cnt = r_tout_cnt;
        w_tx_shift = r_tx_shift;
        w_miso     = 1'b0;
        w_rx_data  = r_rx_data;
        w_rx_valid = 1'b0;
        w_err      = 1'b0;
        w_abort    = 1'b0;
        w_rd_seen  = r_rd_seen;
        w_frame    = {r_shift, MOSI};
        w_tout_inc = r_tout_cnt + 1'b1;

        if (SS_n) begin
            // Deselect wins in every state; only an in-flight transfer counts as an abort.
            w_state   = S_IDLE;
            w_bit_cnt = '0;
            if (r_state == S_RECV || r_state == S_TX_WAIT || r_state == S_SEND)
                w_abort = 1'b1;
            if (r_state == S_SEND)
                w_rd_seen = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_shift   = {{(c_w-2){1'b0}}, MOSI};
                    w_bit_cnt = c_bcw'(1);
                    w_state   = S_RECV;
                end
                S_RECV: begin
                    w_shift   = w_frame[c_w-2:0];
                    w_bit_cnt = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == c_last_bit) begin
                        case (w_frame[c_w-1:c_w-2])
                            c_op_wr_addr, c_op_wr_data: begin
                                w_rx_data  = w_frame;
                                w_rx_valid = 1'b1;
                                w_state    = S_DONE;
                            end
                            c_op_rd_addr: begin
                                w_rx_data  = w_frame;
                                w_rx_valid = 1'b1;
                                w_rd_seen  = 1'b1;
                                w_state    = S_DONE;
                            end
                            default: begin
                                if (r_rd_seen) begin
                                    w_rx_data  = w_frame;
                                    w_rx_valid = 1'b1;
                                    w_tout_cnt = '0;
                                    w_state    = S_TX_WAIT;
                                end else begin
                                    w_err   = 1'b1;
                                    w_state = S_DONE;
                                end
                            end
                        endcase
                    end
                end
                S_TX_WAIT: begin
                    w_tout_cnt = w_tout_inc;
                    if (tx_valid) begin
                        // MSB goes out on the sampling edge; the rest wait in the shifter.
                        w_miso     = tx_data[DATA_W-1];
                        w_tx_shift = tx_data[DATA_W-2:0];
                        w_bit_cnt  = c_bcw'(1);
                        w_state    = S_SEND;
                    end else if (w_tout_inc == c_tout) begin
                        w_err   = 1'b1;
                        w_state = S_DONE;
                    end
                end
                S_SEND: begin
                    if (r_bit_cnt == c_tx_bits) begin
                        w_rd_seen = 1'b0;
                        w_bit_cnt = '0;
                        w_state   = S_DONE;
                    end else begin
                        w_miso     = r_tx_shift[DATA_W-2];
                        w_tx_shift = {r_tx_shift[DATA_W-3:0], 1'b0};
                        w_bit_cnt  = r_bit_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    w_state = S_DONE;
                end
                default: begin
                    w_state = S_IDLE;
                end
            endcase
        end
    end

    assign MISO     = r_miso;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
    assign err      = r_err;
    assign abort    = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_param
// Brief    : Directed self-checking bench for spi_slave_param (DATA_W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_param;

    localparam int DATA_W     = 8;
    localparam int TX_TIMEOUT = 16;
    localparam int W          = DATA_W + 2;

    logic              CLK = 1'b0;
    logic              rst;
    logic              SS_n;
    logic              MOSI;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              MISO;
    logic              rx_valid;
    logic [W-1:0]      rx_data;
    logic              err;
    logic              abort;

    int checks   = 0;
    int failures = 0;

    spi_slave_param #(.DATA_W(DATA_W), .TX_TIMEOUT(TX_TIMEOUT)) dut (
        .CLK     (CLK),
        .rst     (rst),
        .SS_n    (SS_n),
        .MOSI    (MOSI),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .MISO    (MISO),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .err     (err),
        .abort   (abort)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic ss_high(output logic ab);
        SS_n = 1'b1; MOSI = 1'b0;
        tick();
        ab = abort;
    endtask

    // Shifts the first nbits of f MSB-first and records what the DUT reported.
    task automatic shift_frame(input logic [W-1:0] f, input int nbits,
                               output int rxv_cnt, output int rxv_edge,
                               output int err_cnt, output int err_edge,
                               output int miso_hi);
        rxv_cnt = 0; rxv_edge = -1; err_cnt = 0; err_edge = -1; miso_hi = 0;
        for (int k = 1; k <= nbits; k++) begin
            SS_n = 1'b0; MOSI = f[W-k];
            tick();
            if (rx_valid !== 1'b0) begin rxv_cnt++; rxv_edge = k; end
            if (err !== 1'b0) begin err_cnt++; err_edge = k; end
            if (MISO !== 1'b0) miso_hi++;
        end
    endtask

    task automatic test_reset();
        int rc, re, ec, ee, mh;
        logic ab;
        ss_high(ab);
        shift_frame(10'h2D4, W, rc, re, ec, ee, mh);
        ss_high(ab);
        shift_frame(10'h3FF, 4, rc, re, ec, ee, mh);
        rst = 1'b1; SS_n = 1'b0; MOSI = 1'b1;
        tick();
        checks++; if (MISO !== 1'b0) begin failures++; $display("FAIL reset_miso: got %b expected 0", MISO); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (abort !== 1'b0) begin failures++; $display("FAIL reset_abort: got %b expected 0", abort); end
        checks++; if (rx_data !== 10'h000) begin failures++; $display("FAIL reset_rx_data: got %h expected 000", rx_data); end
        rst = 1'b0;
        rc = 0;
        for (int k = 0; k < W; k++) begin
            SS_n = 1'b1; MOSI = k[0];
            tick();
            if (rx_valid !== 1'b0) rc++;
        end
        checks++; if (rc != 0) begin failures++; $display("FAIL reset_idle_rxv: got %0d expected 0", rc); end
        shift_frame(10'h300, W, rc, re, ec, ee, mh);
        checks++; if (ec != 1) begin failures++; $display("FAIL reset_rdseen_err: got %0d expected 1", ec); end
        checks++; if (rc != 0) begin failures++; $display("FAIL reset_rdseen_rxv: got %0d expected 0", rc); end
    endtask

    task automatic test_write();
        int rc, re, ec, ee, mh;
        logic ab;
        ss_high(ab);
        shift_frame(10'h0D4, W, rc, re, ec, ee, mh);
        checks++; if (rc != 1) begin failures++; $display("FAIL wr0_rxv_cnt: got %0d expected 1", rc); end
        checks++; if (re != 10) begin failures++; $display("FAIL wr0_rxv_edge: got %0d expected 10", re); end
        checks++; if (rx_data !== 10'h0D4) begin failures++; $display("FAIL wr0_data: got %h expected 0d4", rx_data); end
        checks++; if (mh != 0) begin failures++; $display("FAIL wr0_miso: got %0d expected 0", mh); end
        checks++; if (ec != 0) begin failures++; $display("FAIL wr0_err: got %0d expected 0", ec); end
        ss_high(ab);
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL wr0_pulse_len: got %b expected 0", rx_valid); end
        checks++; if (rx_data !== 10'h0D4) begin failures++; $display("FAIL wr0_hold: got %h expected 0d4", rx_data); end
        checks++; if (ab !== 1'b0) begin failures++; $display("FAIL wr0_no_abort: got %b expected 0", ab); end
        shift_frame(10'h1F2, W, rc, re, ec, ee, mh);
        checks++; if (rx_data !== 10'h1F2) begin failures++; $display("FAIL wr1_data: got %h expected 1f2", rx_data); end
        checks++; if (rc != 1) begin failures++; $display("FAIL wr1_rxv_cnt: got %0d expected 1", rc); end
    endtask

    task automatic test_seq_error();
        int rc, re, ec, ee, mh;
        reset_dut();
        shift_frame(10'h3AC, W, rc, re, ec, ee, mh);
        checks++; if (ec != 1) begin failures++; $display("FAIL seq_err_cnt: got %0d expected 1", ec); end
        checks++; if (ee != 10) begin failures++; $display("FAIL seq_err_edge: got %0d expected 10", ee); end
        checks++; if (rc != 0) begin failures++; $display("FAIL seq_rxv: got %0d expected 0", rc); end
        checks++; if (mh != 0) begin failures++; $display("FAIL seq_miso: got %0d expected 0", mh); end
        checks++; if (rx_data !== 10'h000) begin failures++; $display("FAIL seq_rx_data: got %h expected 000", rx_data); end
        tick();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL seq_err_len: got %b expected 0", err); end
    endtask

    task automatic test_read();
        int rc, re, ec, ee, mh;
        logic ab;
        logic [7:0] dv [2];
        logic [7:0] d;
        dv[0] = 8'hF0;
        dv[1] = 8'h5A;
        for (int i = 0; i < 2; i++) begin
            d = dv[i];
            ss_high(ab);
            shift_frame(10'h2D4, W, rc, re, ec, ee, mh);
            checks++; if (rx_data !== 10'h2D4) begin failures++; $display("FAIL rd%0d_addr_data: got %h expected 2d4", i, rx_data); end
            ss_high(ab);
            shift_frame(10'h300, W, rc, re, ec, ee, mh);
            checks++; if (rc != 1 || ec != 0) begin failures++; $display("FAIL rd%0d_cmd: got rxv=%0d err=%0d expected rxv=1 err=0", i, rc, ec); end
            checks++; if (rx_data !== 10'h300) begin failures++; $display("FAIL rd%0d_cmd_data: got %h expected 300", i, rx_data); end
            SS_n = 1'b0; tx_valid = 1'b1; tx_data = d;
            tick();
            tx_valid = 1'b0; tx_data = 8'h00;
            checks++; if (MISO !== d[7]) begin failures++; $display("FAIL rd%0d_miso_b7: got %b expected %b", i, MISO, d[7]); end
            for (int b = 1; b < 8; b++) begin
                tick();
                checks++; if (MISO !== d[7-b]) begin failures++; $display("FAIL rd%0d_miso_b%0d: got %b expected %b", i, 7-b, MISO, d[7-b]); end
            end
            tick();
            checks++; if (MISO !== 1'b0) begin failures++; $display("FAIL rd%0d_miso_end: got %b expected 0", i, MISO); end
            ss_high(ab);
            checks++; if (ab !== 1'b0) begin failures++; $display("FAIL rd%0d_no_abort: got %b expected 0", i, ab); end
        end
        shift_frame(10'h300, W, rc, re, ec, ee, mh);
        checks++; if (ec != 1 || rc != 0) begin failures++; $display("FAIL rd_seen_cleared: got err=%0d rxv=%0d expected err=1 rxv=0", ec, rc); end
    endtask

    task automatic test_timeout();
        int rc, re, ec, ee, mh;
        logic ab;
        ss_high(ab);
        shift_frame(10'h203, W, rc, re, ec, ee, mh);
        ss_high(ab);
        shift_frame(10'h300, W, rc, re, ec, ee, mh);
        checks++; if (rc != 1) begin failures++; $display("FAIL to_cmd_rxv: got %0d expected 1", rc); end
        ec = 0; ee = -1; mh = 0;
        tx_valid = 1'b0;
        for (int k = 1; k <= TX_TIMEOUT; k++) begin
            SS_n = 1'b0;
            tick();
            if (err !== 1'b0) begin ec++; ee = k; end
            if (MISO !== 1'b0) mh++;
        end
        checks++; if (ec != 1) begin failures++; $display("FAIL to_err_cnt: got %0d expected 1", ec); end
        checks++; if (ee != 16) begin failures++; $display("FAIL to_err_edge: got %0d expected 16", ee); end
        checks++; if (mh != 0) begin failures++; $display("FAIL to_miso_wait: got %0d expected 0", mh); end
        tx_valid = 1'b1; tx_data = 8'hFF; mh = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (MISO !== 1'b0) mh++;
        end
        tx_valid = 1'b0; tx_data = 8'h00;
        checks++; if (mh != 0) begin failures++; $display("FAIL to_late_txv: got %0d expected 0", mh); end
        ss_high(ab);
        checks++; if (ab !== 1'b0) begin failures++; $display("FAIL to_done_abort: got %b expected 0", ab); end
        shift_frame(10'h300, W, rc, re, ec, ee, mh);
        checks++; if (rc != 1 || ec != 0) begin failures++; $display("FAIL to_rdseen_kept: got rxv=%0d err=%0d expected rxv=1 err=0", rc, ec); end
        ss_high(ab);
        checks++; if (ab !== 1'b1) begin failures++; $display("FAIL to_wait_abort: got %b expected 1", ab); end
        ss_high(ab);
        checks++; if (ab !== 1'b0) begin failures++; $display("FAIL to_abort_len: got %b expected 0", ab); end
    endtask

    task automatic test_abort();
        int rc, re, ec, ee, mh;
        logic ab;
        ss_high(ab);
        shift_frame(10'h1F2, W, rc, re, ec, ee, mh);
        ss_high(ab);
        shift_frame(10'h0AA, 7, rc, re, ec, ee, mh);
        ss_high(ab);
        checks++; if (ab !== 1'b1) begin failures++; $display("FAIL ab_recv: got %b expected 1", ab); end
        checks++; if (rc != 0 || rx_valid !== 1'b0) begin failures++; $display("FAIL ab_recv_rxv: got %0d/%b expected 0/0", rc, rx_valid); end
        checks++; if (rx_data !== 10'h1F2) begin failures++; $display("FAIL ab_recv_data: got %h expected 1f2", rx_data); end
        ss_high(ab);
        checks++; if (ab !== 1'b0) begin failures++; $display("FAIL ab_len: got %b expected 0", ab); end
        shift_frame(10'h005, W, rc, re, ec, ee, mh);
        checks++; if (rx_data !== 10'h005 || rc != 1) begin failures++; $display("FAIL ab_next_frame: got %h rxv=%0d expected 005 rxv=1", rx_data, rc); end
        ss_high(ab);
        shift_frame(10'h2D4, W, rc, re, ec, ee, mh);
        ss_high(ab);
        shift_frame(10'h300, W, rc, re, ec, ee, mh);
        SS_n = 1'b0; tx_valid = 1'b1; tx_data = 8'hFF;
        tick();
        tx_valid = 1'b0; tx_data = 8'h00;
        tick();
        checks++; if (MISO !== 1'b1) begin failures++; $display("FAIL ab_send_active: got %b expected 1", MISO); end
        ss_high(ab);
        checks++; if (ab !== 1'b1) begin failures++; $display("FAIL ab_send: got %b expected 1", ab); end
        checks++; if (MISO !== 1'b0) begin failures++; $display("FAIL ab_send_miso: got %b expected 0", MISO); end
        shift_frame(10'h300, W, rc, re, ec, ee, mh);
        checks++; if (ec != 1 || rc != 0) begin failures++; $display("FAIL ab_send_rdseen: got err=%0d rxv=%0d expected err=1 rxv=0", ec, rc); end
    endtask

    initial begin
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_write();
        test_seq_error();
        test_read();
        test_timeout();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
